// File: rtl/alu_sched_pkg.sv
// Shared state encodings, command word layout and the command validity rule
// for the ALU command scheduler.
package alu_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] OP_ADD1 = 4'h1;
  localparam logic [3:0] OP_ADD2 = 4'h2;
  localparam logic [3:0] OP_SUB1 = 4'h3;
  localparam logic [3:0] OP_SUB2 = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_COMP = 4'h9;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 28;
  localparam int SHAMT_MSB = 27;
  localparam int SHAMT_LSB = 26;
  localparam int CONST_MSB = 25;
  localparam int CONST_LSB = 22;
  localparam int OP2_MSB   = 21;
  localparam int OP2_LSB   = 14;
  localparam int OP1_MSB   = 13;
  localparam int OP1_LSB   = 6;
  localparam int ADDR_MSB  = 5;
  localparam int ADDR_LSB  = 0;

  // Highest ALU register address a command may target.
  localparam logic [5:0] MAX_ADDR = 6'd15;

  typedef struct packed {
    logic [3:0] opc;
    logic [1:0] shamt;
    logic [3:0] cnst;
    logic [7:0] op2;
    logic [7:0] op1;
    logic [5:0] addr;
  } alu_cmd_t;

  function automatic logic cmd_valid(input logic [3:0] opc, input logic [5:0] addr);
    return (opc >= OP_ADD1) && (opc <= OP_COMP) && (addr <= MAX_ADDR);
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around, as one-hot, index and an any-request flag.
module alu_rr_picker
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_scheduler.sv
// Round-robin scheduler sharing one ALU APB slave among NUM_REQ requesters.
// Optional ACCESS-phase timeout enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_cmd_scheduler
  import alu_sched_pkg::*;
#(
  parameter int          NUM_REQ  = 4,
  parameter int          ALU_LAT  = 4,
  parameter logic [31:0] APB_ADDR = 32'h0,
  parameter int          TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  output logic                    busy,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [31:0]             paddr,
  output logic [31:0]             pwdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SET_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(ALU_LAT - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ALU_LAT < 1 || TIMEOUT < 1) begin : g_param_check
    $error("alu_cmd_scheduler: parameter out of range");
  end

  logic [2:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] owner_oh;
  logic [SET_W-1:0]   settle_cnt;
  logic               err_cap;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   next_ptr;
  alu_cmd_t           sel_cmd;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] access_cnt;
`endif

  alu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) sel_cmd = req_cmd[32*i +: 32];
    end
  end

  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign busy     = (state != ST_IDLE);
  assign paddr    = psel ? APB_ADDR : 32'h0;

  // gnt/done/err are single-cycle pulses, so they fall back to 0 unless set below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner_oh   <= '0;
      settle_cnt <= '0;
      err_cap    <= 1'b0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
      access_cnt <= '0;
`endif
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner_oh <= pick_onehot;
            gnt      <= pick_onehot;
            ptr      <= next_ptr;
            if (cmd_valid(sel_cmd.opc, sel_cmd.addr)) begin
              state  <= ST_SETUP;
              psel   <= 1'b1;
              pwrite <= 1'b1;
              pwdata <= sel_cmd;
            end else begin
              state <= ST_DONE;
              done  <= pick_onehot;
              err   <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
`ifdef ALU_SCHED_TIMEOUT_EN
          access_cnt <= '0;
`endif
        end
        ST_ACCESS: begin
          if (pready) begin
            state      <= ST_SETTLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            err_cap    <= pslverr;
            settle_cnt <= SETTLE_LOAD;
          end
`ifdef ALU_SCHED_TIMEOUT_EN
          else if (access_cnt == TO_LAST) begin
            state   <= ST_DONE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            done    <= owner_oh;
            err     <= 1'b1;
          end else begin
            access_cnt <= access_cnt + TO_W'(1);
          end
`endif
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_DONE;
            done  <= owner_oh;
            err   <= err_cap;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
